sync_fifo_ctrl: RTL
===================

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 4, address width; DEPTH = 2**ADDR_SIZE.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2, almost-full threshold in words.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2, almost-empty threshold in words.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 flush  input  1  synchronous clear of all FIFO contents.
REQ-009 winc  input  1  write request.
REQ-010 wdata  input  DATA_SIZE  write data.
REQ-011 rinc  input  1  read request.
REQ-012 rdata  output  DATA_SIZE  registered read data.
REQ-013 rvalid  output  1  high for one cycle when rdata holds a newly read word.
REQ-014 wfull  output  1  FIFO holds DEPTH words.
REQ-015 rempty  output  1  FIFO holds 0 words.
REQ-016 afull  output  1  count >= AFULL_LVL.
REQ-017 aempty  output  1  count <= AEMPTY_LVL.
REQ-018 count  output  ADDR_SIZE+1  current occupancy, 0..DEPTH.

Function
REQ-019 Storage SHALL be a DEPTH x DATA_SIZE dual-port array with registered read and write ports on clk.
REQ-020 Write accept SHALL be winc && !wfull && !flush: wdata is stored at wptr, wptr advances by 1 and wraps to 0 after DEPTH-1.
REQ-021 Read accept SHALL be rinc && !rempty && !flush: mem[rptr] is loaded into rdata on the same edge, rvalid is 1 in the following cycle, and rptr advances with wrap.
REQ-022 Read latency SHALL be exactly 1 cycle from the accepting edge; rdata SHALL hold its value when no read is accepted.
REQ-023 rvalid SHALL be 0 in every cycle that does not follow an accepted read.
REQ-024 winc while full SHALL be dropped with no state change, even if a read is accepted in the same cycle.
REQ-025 rinc while empty SHALL be ignored, even if a write is accepted in the same cycle; no write-through occurs.
REQ-026 Simultaneous accepted read and write SHALL leave count unchanged.
REQ-027 count SHALL be a register: +1 on write-only, -1 on read-only, unchanged otherwise.
REQ-028 wfull, rempty, afull and aempty SHALL be decoded from the count register, so they change in the cycle after the causing edge.
REQ-029 flush SHALL have priority over winc and rinc: wptr, rptr and count go to 0 and rvalid goes to 0; rdata and memory contents are retained.

Reset
REQ-030 rst SHALL clear wptr, rptr, count, rvalid and rdata to 0 asynchronously; rempty=1, aempty=1, wfull=0, afull=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 rst asserted mid-transfer SHALL abort any in-flight read; rvalid is 0 on the first edge after release.

Configuration
REQ-033 With macro SYNC_FIFO_ERR_FLAG_EN defined, the block SHALL add outputs overflow (1) and underflow (1).
REQ-034 overflow SHALL be sticky-set on a dropped write, underflow SHALL be sticky-set on an ignored read, and both SHALL be cleared only by rst or flush.
REQ-035 Without SYNC_FIFO_ERR_FLAG_EN, both ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset then idle: rempty=1, aempty=1, count=0, rvalid=0, rdata=0.
REQ-037 Write 16 words 0x00..0x0F (DEPTH 16): wfull=1 and count=16 after the last edge; afull first asserts when count=14; a 17th write with winc=1 leaves count=16 and sets overflow (macro on).
REQ-038 Read all 16 words: rdata sequence is 0x00..0x0F, each valid one cycle after rinc; rempty=1 after the last read; an extra rinc sets underflow.
REQ-039 Hold count=5 and assert winc and rinc together for 20 cycles: count stays 5, data order is preserved, and pointers wrap past 15 correctly.
REQ-040 Full FIFO with winc=1 and rinc=1: the read is accepted, the write is dropped, and count goes to 15; empty FIFO with winc=1 and rinc=1: the write is accepted, rvalid=0, and count goes to 1.
REQ-041 flush at count=9 with winc=1 and rinc=1: next cycle count=0, rempty=1, rvalid=0, and overflow/underflow are cleared.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller with registered read port and occupancy flags.
// Optional sticky overflow/underflow outputs are enabled by defining SYNC_FIFO_ERR_FLAG_EN.
module sync_fifo_ctrl #(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_SIZE  = 4,
    parameter int AFULL_LVL  = (1 << ADDR_SIZE) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 winc,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rinc,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rvalid,
    output logic                 wfull,
    output logic                 rempty,
    output logic                 afull,
    output logic                 aempty,
    output logic [ADDR_SIZE:0]   count
`ifdef SYNC_FIFO_ERR_FLAG_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_CNT   = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] AFULL_CNT  = (ADDR_SIZE+1)'(AFULL_LVL);
    localparam logic [ADDR_SIZE:0] AEMPTY_CNT = (ADDR_SIZE+1)'(AEMPTY_LVL);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0] wptr;
    logic [ADDR_SIZE-1:0] rptr;
    logic                 wr_en;
    logic                 rd_en;

    // Accept decisions and status flags, all decoded from the registered count.
    always_comb begin
        wfull  = count == FULL_CNT;
        rempty = count == '0;
        afull  = count >= AFULL_CNT;
        aempty = count <= AEMPTY_CNT;
        wr_en  = winc && !wfull && !flush;
        rd_en  = rinc && !rempty && !flush;
    end

    // Storage array write port; contents survive reset and flush.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= wdata;
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (rd_en)
                rptr <= rptr + 1'b1;
            if (wr_en && !rd_en)
                count <= count + 1'b1;
            else if (rd_en && !wr_en)
                count <= count - 1'b1;
        end
    end

    // Registered read port; rdata holds its last word until the next accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en)
                rdata <= mem[rptr];
        end
    end

`ifdef SYNC_FIFO_ERR_FLAG_EN
    // Sticky error flags: set on a dropped write or ignored read, cleared by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && wfull)
                overflow <= 1'b1;
            if (rinc && rempty)
                underflow <= 1'b1;
        end
    end
`endif
endmodule
